// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP engine: FSM encoding, window geometry and
// the neighbour-to-code-bit map.
package lbp_pkg;

   typedef enum logic [2:0] {
      StIdle, StFill, StShift, StCalc, StWrite, StBorder, StDone
   } state_e;

   localparam int unsigned WinSize     = 9;
   localparam logic [3:0]  CenterSlot  = 4'd4;
   localparam logic [3:0]  LastFillRd  = 4'd8;
   localparam logic [3:0]  LastShiftRd = 4'd2;

   // Window slots are row-major (0 = top-left); code bit b maps to slot b, skipping the centre.
   function automatic logic [3:0] nbr_slot(int unsigned b);
      return (b < 4) ? 4'(b) : 4'(b + 1);
   endfunction

endpackage

// File: rtl/lbp_cmp.sv
// Combinational LBP comparator: 3x3 window plus compare mode -> 8-bit code.
module lbp_cmp
   import lbp_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic [DW-1:0] win_i [WinSize],
   input  logic          mode_i,
   input  logic [DW-1:0] thr_i,
   output logic [7:0]    code_o
);

   logic [DW:0] sum;

   always_comb begin
      // One extra bit so centre + threshold never wraps.
      sum = {1'b0, win_i[CenterSlot]} + (mode_i ? {1'b0, thr_i} : '0);
      code_o = '0;
      for (int unsigned b = 0; b < 8; b++) begin
         code_o[b] = ({1'b0, win_i[nbr_slot(b)]} >= sum);
      end
   end

endmodule

// File: rtl/lbp_engine.sv
// LBP engine: walks the image in raster order through a reusable 3x3 window
// and writes one LBP code per processed pixel.
module lbp_engine
   import lbp_pkg::*;
#(
   parameter int unsigned IMG_W = 128,
   parameter int unsigned IMG_H = 128,
   parameter int unsigned DW    = 8,
   parameter int unsigned AW    = 14
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic          mode_i,
   input  logic [DW-1:0] thr_i,
   input  logic          border_en_i,
   output logic          busy_o,
   output logic [AW-1:0] gray_addr_o,
   output logic          gray_req_o,
   input  logic          gray_ready_i,
   input  logic [DW-1:0] gray_data_i,
   output logic [AW-1:0] lbp_addr_o,
   output logic          lbp_valid_o,
   output logic [7:0]    lbp_data_o,
   output logic          finish_o
);

   localparam logic [AW-1:0] XLast = AW'(IMG_W - 1);
   localparam logic [AW-1:0] YLast = AW'(IMG_H - 1);
   localparam logic [AW-1:0] Width = AW'(IMG_W);
   localparam logic [AW-1:0] One   = AW'(1);

   state_e        state_q;
   logic [AW-1:0] x_q, y_q;
   logic [3:0]    rd_cnt_q, pend_slot_q;
   logic          pend_q, mode_q, border_q;
   logic [DW-1:0] thr_q;
   logic [DW-1:0] win_q   [WinSize];
   logic [DW-1:0] win_cur [WinSize];
   logic          busy_q, gray_req_q, lbp_valid_q, finish_q;
   logic [AW-1:0] gray_addr_q, lbp_addr_q;
   logic [7:0]    lbp_data_q, code;

   logic [AW-1:0] nx, ny;
   logic          last_pix, cur_border, nxt_border, row_wrap, rd_last;
   logic [3:0]    nxt_slot;

   function automatic logic is_border(logic [AW-1:0] x, logic [AW-1:0] y);
      return (x == '0) || (y == '0) || (x == XLast) || (y == YLast);
   endfunction

   function automatic logic [3:0] slot_of(logic shift, logic [3:0] cnt);
      return shift ? 4'(cnt * 4'd3 + 4'd2) : cnt;
   endfunction

   function automatic logic [AW-1:0] addr_of(logic [AW-1:0] x, logic [AW-1:0] y,
                                             logic [3:0] slot);
      logic [AW-1:0] r, c;
      r = AW'(slot / 4'd3);
      c = AW'(slot % 4'd3);
      return (y + r - One) * Width + x + c - One;
   endfunction

   // Last read's data is merged straight in so the code is ready the cycle it returns.
   always_comb begin
      win_cur = win_q;
      if (pend_q) win_cur[pend_slot_q] = gray_data_i;
   end

   always_comb begin
      cur_border = is_border(x_q, y_q);
      if (border_q) begin
         last_pix = (x_q == XLast) && (y_q == YLast);
         row_wrap = (x_q == XLast);
         nx       = row_wrap ? '0 : x_q + One;
      end else begin
         last_pix = (x_q == XLast - One) && (y_q == YLast - One);
         row_wrap = (x_q == XLast - One);
         nx       = row_wrap ? One : x_q + One;
      end
      ny         = row_wrap ? y_q + One : y_q;
      nxt_border = border_q && is_border(nx, ny);
      rd_last    = (state_q == StShift) ? (rd_cnt_q == LastShiftRd) : (rd_cnt_q == LastFillRd);
      nxt_slot   = slot_of(state_q == StShift, rd_cnt_q + 4'd1);
   end

   lbp_cmp #(.DW(DW)) u_cmp (
      .win_i  (win_cur),
      .mode_i (mode_q),
      .thr_i  (thr_q),
      .code_o (code)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         x_q         <= '0;
         y_q         <= '0;
         rd_cnt_q    <= '0;
         pend_q      <= 1'b0;
         pend_slot_q <= '0;
         mode_q      <= 1'b0;
         border_q    <= 1'b0;
         thr_q       <= '0;
         win_q       <= '{default: '0};
         busy_q      <= 1'b0;
         gray_req_q  <= 1'b0;
         gray_addr_q <= '0;
         lbp_valid_q <= 1'b0;
         lbp_addr_q  <= '0;
         lbp_data_q  <= '0;
         finish_q    <= 1'b0;
      end else begin
         lbp_valid_q <= 1'b0;
         finish_q    <= 1'b0;
         pend_q      <= 1'b0;
         if (pend_q) win_q[pend_slot_q] <= gray_data_i;
         unique case (state_q)
            StIdle, StDone: begin
               state_q <= StIdle;
               if (start_i) begin
                  mode_q   <= mode_i;
                  thr_q    <= thr_i;
                  border_q <= border_en_i;
                  busy_q   <= 1'b1;
                  rd_cnt_q <= '0;
                  if (border_en_i) begin
                     x_q     <= '0;
                     y_q     <= '0;
                     state_q <= StBorder;
                  end else begin
                     x_q         <= One;
                     y_q         <= One;
                     gray_req_q  <= 1'b1;
                     gray_addr_q <= '0;
                     state_q     <= StFill;
                  end
               end
            end
            StFill, StShift: begin
               if (gray_ready_i) begin
                  pend_q      <= 1'b1;
                  pend_slot_q <= slot_of(state_q == StShift, rd_cnt_q);
                  if (rd_last) begin
                     gray_req_q <= 1'b0;
                     state_q    <= StCalc;
                  end else begin
                     rd_cnt_q    <= rd_cnt_q + 4'd1;
                     gray_addr_q <= addr_of(x_q, y_q, nxt_slot);
                  end
               end
            end
            StCalc, StBorder: begin
               lbp_valid_q <= 1'b1;
               lbp_data_q  <= (state_q == StCalc) ? code : 8'h00;
               lbp_addr_q  <= addr_of(x_q, y_q, CenterSlot);
               state_q     <= StWrite;
            end
            StWrite: begin
               if (last_pix) begin
                  busy_q   <= 1'b0;
                  finish_q <= 1'b1;
                  state_q  <= StDone;
               end else begin
                  x_q      <= nx;
                  y_q      <= ny;
                  rd_cnt_q <= '0;
                  if (nxt_border) begin
                     state_q <= StBorder;
                  end else if (!cur_border && !row_wrap) begin
                     for (int r = 0; r < 3; r++) begin
                        win_q[r*3]   <= win_q[r*3+1];
                        win_q[r*3+1] <= win_q[r*3+2];
                     end
                     gray_req_q  <= 1'b1;
                     gray_addr_q <= addr_of(nx, ny, 4'd2);
                     state_q     <= StShift;
                  end else begin
                     gray_req_q  <= 1'b1;
                     gray_addr_q <= addr_of(nx, ny, 4'd0);
                     state_q     <= StFill;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign gray_req_o  = gray_req_q;
   assign gray_addr_o = gray_addr_q;
   assign lbp_valid_o = lbp_valid_q;
   assign lbp_addr_o  = lbp_addr_q;
   assign lbp_data_o  = lbp_data_q;
   assign finish_o    = finish_q;

endmodule

// File: tb/tb_lbp_engine.sv
// Bench for lbp_engine on a 4x4 image: directed frames plus randomized frames
// against a raster-order LBP reference model.
module tb_lbp_engine;

   localparam int W = 4, H = 4, NPIX = W * H;
   localparam int unsigned DW = 8, AW = 4;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
   logic          border_en = 1'b0, gray_ready = 1'b0;
   logic [DW-1:0] thr = '0, gray_data = '0;
   logic          busy, gray_req, lbp_valid, finish;
   logic [AW-1:0] gray_addr, lbp_addr;
   logic [7:0]    lbp_data;

   int n_vec = 0, n_err = 0;
   logic [7:0] img [NPIX];
   int         wr_addr [$];
   logic [7:0] wr_data [$];
   int         exp_addr [$];
   logic [7:0] exp_data [$];
   int exp_reads = 0, reads = 0, fin_cnt = 0, stall_pct = 0, stall_at = -1, force_left = 0;
   logic prev_stall = 1'b0, prev_valid = 1'b0, hs_p1 = 1'b0, hs_p2 = 1'b0, hs;
   logic [AW-1:0] prev_addr = '0;

   always #5 clk = ~clk;

   lbp_engine #(.IMG_W(W), .IMG_H(H), .DW(DW), .AW(AW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .mode_i       (mode),
      .thr_i        (thr),
      .border_en_i  (border_en),
      .busy_o       (busy),
      .gray_addr_o  (gray_addr),
      .gray_req_o   (gray_req),
      .gray_ready_i (gray_ready),
      .gray_data_i  (gray_data),
      .lbp_addr_o   (lbp_addr),
      .lbp_valid_o  (lbp_valid),
      .lbp_data_o   (lbp_data),
      .finish_o     (finish)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit pix_border(int a);
      int x = a % W, y = a / W;
      return (x == 0) || (y == 0) || (x == W - 1) || (y == H - 1);
   endfunction

   // Reference: every pixel in raster order, neighbours by (dx,dy) in code-bit order.
   function automatic void build_exp(input logic m, input logic [7:0] t, input logic be);
      int dx [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
      int dy [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
      exp_addr.delete();
      exp_data.delete();
      exp_reads = 0;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            if (pix_border(y * W + x)) begin
               if (be) begin
                  exp_addr.push_back(y * W + x);
                  exp_data.push_back(8'h00);
               end
            end else begin
               int lim = int'(img[y * W + x]) + (m ? int'(t) : 0);
               logic [7:0] c = '0;
               for (int b = 0; b < 8; b++)
                  c[b] = (int'(img[(y + dy[b]) * W + x + dx[b]]) >= lim);
               exp_addr.push_back(y * W + x);
               exp_data.push_back(c);
               exp_reads += (x == 1) ? 9 : 3;
            end
         end
      end
   endfunction

   function automatic logic [31:0] got(int a);
      for (int i = 0; i < wr_addr.size(); i++)
         if (wr_addr[i] == a) return 32'(wr_data[i]);
      return 32'hDEAD;
   endfunction

   task automatic chk_reset(input string tag);
      chk(tag, 32'({busy, gray_req, lbp_valid, finish, gray_addr, lbp_addr, lbp_data}), 0);
   endtask

   always @(posedge clk) if (gray_req && gray_ready) gray_data <= img[gray_addr];

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
         prev_valid = 1'b0;
         hs_p1      = 1'b0;
         hs_p2      = 1'b0;
         gray_ready = 1'b1;
      end else begin
         if (prev_stall) begin
            chk("req_hold", 32'(gray_req), 1);
            chk("addr_hold", 32'(gray_addr), 32'(prev_addr));
         end
         if (lbp_valid) begin
            wr_addr.push_back(int'(lbp_addr));
            wr_data.push_back(lbp_data);
            if (!pix_border(int'(lbp_addr))) chk("valid_latency", 32'(hs_p2), 1);
         end
         if (finish) begin
            fin_cnt++;
            chk("finish_after_valid", 32'(prev_valid), 1);
            chk("busy_at_finish", 32'(busy), 0);
         end
         prev_valid = lbp_valid;
         if (force_left > 0) begin
            gray_ready = 1'b0;
            force_left--;
         end else if (stall_at >= 0 && reads == stall_at) begin
            gray_ready = 1'b0;
            force_left = 9;
            stall_at   = -1;
         end else begin
            gray_ready = (int'($urandom_range(0, 99)) >= stall_pct);
         end
         hs = gray_req && gray_ready;
         if (hs) reads++;
         hs_p2      = hs_p1;
         hs_p1      = hs;
         prev_stall = gray_req && !gray_ready;
         prev_addr  = gray_addr;
      end
   end

   task automatic run_frame(input string tag, input logic m, input logic [7:0] t,
                            input logic be, input bit poke);
      int cyc = 0;
      build_exp(m, t, be);
      wr_addr.delete();
      wr_data.delete();
      reads   = 0;
      fin_cnt = 0;
      @(negedge clk);
      mode = m; thr = t; border_en = be; start = 1'b1;
      @(negedge clk);
      start = 1'b0; mode = ~m; thr = ~t; border_en = ~be;
      chk({tag, "/busy"}, 32'(busy), 1);
      if (poke) begin
         repeat (5) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      while (fin_cnt == 0 && cyc < 2000) begin
         @(posedge clk);
         cyc++;
      end
      repeat (4) @(negedge clk);
      chk({tag, "/finish_count"}, 32'(fin_cnt), 1);
      chk({tag, "/write_count"}, 32'(wr_addr.size()), 32'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size(); i++) begin
         chk({tag, "/addr"}, (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hDEAD,
             32'(exp_addr[i]));
         chk({tag, "/code"}, (i < wr_data.size()) ? 32'(wr_data[i]) : 32'hDEAD,
             32'(exp_data[i]));
      end
      chk({tag, "/reads"}, 32'(reads), 32'(exp_reads));
      chk({tag, "/idle_busy"}, 32'(busy), 0);
   endtask

   initial begin
      foreach (img[i]) img[i] = '0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset("idle");

      foreach (img[i]) img[i] = 8'd50;
      run_frame("flat_m0", 1'b0, 8'd0, 1'b0, 1'b0);
      chk("flat_m0/code5", got(5), 32'hFF);
      chk("flat_m0/code10", got(10), 32'hFF);
      run_frame("flat_m1", 1'b1, 8'd1, 1'b0, 1'b0);
      chk("flat_m1/code6", got(6), 32'h00);

      foreach (img[i]) img[i] = 8'(i);
      run_frame("ramp_m0", 1'b0, 8'd0, 1'b0, 1'b0);
      chk("ramp_m0/code5", got(5), 32'hF0);
      stall_at = 10;
      run_frame("ramp_stall", 1'b0, 8'd0, 1'b0, 1'b0);
      run_frame("ramp_border", 1'b0, 8'd0, 1'b1, 1'b0);
      chk("ramp_border/code0", got(0), 32'h00);

      foreach (img[i]) img[i] = 8'd250;
      run_frame("sat_thr", 1'b1, 8'd10, 1'b0, 1'b0);

      foreach (img[i]) img[i] = 8'($urandom);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      wr_addr.delete();
      wr_data.delete();
      @(negedge clk);
      chk_reset("abort");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort/no_writes", 32'(wr_addr.size()), 0);
      chk_reset("abort/idle");
      run_frame("after_abort", 1'b0, 8'd0, 1'b0, 1'b1);

      for (int k = 0; k < 8; k++) begin
         foreach (img[i]) img[i] = k[0] ? 8'(100 + $urandom_range(0, 3)) : 8'($urandom);
         stall_pct = int'($urandom_range(0, 50));
         run_frame("random", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), k[1]);
      end
      stall_pct = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lbp_engine.md
LBP_ENGINE -- requirements
Module: lbp_engine

Interface
REQ-001 Parameter IMG_W, default 128, image width in pixels (>=3).
REQ-002 Parameter IMG_H, default 128, image height in pixels (>=3).
REQ-003 Parameter DW, default 8, gray pixel width.
REQ-004 Parameter AW, default 14, address width, SHALL satisfy 2^AW >= IMG_W*IMG_H.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse launching a frame; ignored while busy.
REQ-008 mode  input  1  0 = standard compare (n >= c); 1 = threshold compare (n >= c + thr).
REQ-009 thr  input  DW  threshold for mode 1; mode, thr, border_en sampled at accepted start.
REQ-010 border_en  input  1  1 = also write 0x00 for every border pixel.
REQ-011 busy  output  1  high from the cycle after accepted start until finish.
REQ-012 gray_addr  output  AW  raster address of requested pixel.
REQ-013 gray_req  output  1  read request.
REQ-014 gray_ready  input  1  request accepted when gray_req && gray_ready at a clock edge.
REQ-015 gray_data  input  DW  valid the cycle after acceptance.
REQ-016 lbp_addr  output  AW  result address.
REQ-017 lbp_valid  output  1  one-cycle write strobe.
REQ-018 lbp_data  output  8  LBP code.
REQ-019 finish  output  1  one-cycle pulse after last write.

Function
REQ-020 FSM states: IDLE, FILL (9 reads at row start), SHIFT (3 reads, right column), CALC, WRITE, BORDER, DONE.
REQ-021 IDLE -> FILL (or BORDER when border_en and current pixel is border) on start; after WRITE -> SHIFT if next pixel interior in same row, else FILL/BORDER; last pixel -> DONE -> IDLE.
REQ-022 Window reuse: on SHIFT, left/centre columns SHALL shift and only 3 reads issue.
REQ-023 gray_addr/gray_req SHALL hold stable while gray_ready low; no read dropped or duplicated.
REQ-024 Bit map: b0 top-left, b1 top, b2 top-right, b3 left, b4 right, b5 bottom-left, b6 bottom, b7 bottom-right.
REQ-025 Mode 1 sum c+thr computed at DW+1 bits, no wrap; bit = 0 when sum exceeds neighbour.
REQ-026 lbp_valid SHALL assert exactly 1 cycle after the last neighbour's gray_data returns.
REQ-027 Writes in strict raster order; count = (IMG_W-2)*(IMG_H-2), or IMG_W*IMG_H with border_en.
REQ-028 Border pixels issue no reads; lbp_data = 0x00.
REQ-029 finish SHALL pulse the cycle after the final lbp_valid; busy deasserts same cycle.

Reset
REQ-030 On reset low: state IDLE; gray_req, lbp_valid, finish, busy = 0; gray_addr, lbp_addr = 0; lbp_data = 0x00; window cleared.
REQ-031 Reset asserted mid-frame SHALL abort immediately; no further writes until next start.

Structure
REQ-032 State encoding and bit-map constants SHALL live in shared package lbp_pkg.
REQ-033 One sub-module lbp_cmp: combinational 3x3 window + mode/thr -> 8-bit code.

Verification
REQ-034 IMG_W=IMG_H=4, flat image 50, mode 0 -> writes addr 5,6,9,10 all 0xFF, finish after 4th.
REQ-035 Same image, mode 1, thr=1 -> all four codes 0x00.
REQ-036 4x4, pixel = address, mode 0 -> addr 5 code 0xF0.
REQ-037 gray_ready low 10 cycles mid-SHIFT -> identical codes, no duplicate read or write.
REQ-038 border_en=1, 4x4 -> 16 raster-ordered writes, 12 border writes 0x00.
REQ-039 Reset low during FILL, then start -> outputs at reset values, then full correct frame; start while busy ignored.
